// File: rtl/seq_alu_param_if.sv
// Operand/result bundle between the issuing datapath and the sequential ALU.
// The master launches operations and the slave (the ALU) returns results and status.
interface seq_alu_param_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [4:0]       opcode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Zlow;
   logic [WIDTH-1:0] Zhigh;
   logic             div_by_zero;
   logic             illegal_op;

   modport master (
      output start, opcode, A, B,
      input  busy, done, Zlow, Zhigh, div_by_zero, illegal_op
   );

   modport slave (
      input  start, opcode, A, B,
      output busy, done, Zlow, Zhigh, div_by_zero, illegal_op
   );

endinterface

// File: rtl/seq_alu_param.sv
// Parametrised sequential ALU: single-cycle logic/arithmetic/shift ops with a
// registered result, plus iterative signed multiply (radix-2 Booth) and signed
// divide (restoring, on magnitudes) that take WIDTH iteration cycles.
module seq_alu_param #(
   parameter int WIDTH = 32
) (
   input logic            clock,
   input logic            clear,
   seq_alu_param_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [4:0] OP_LOAD = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

   state_t           state;
   state_t           next_state;
   logic [SHW-1:0]   count;

   logic             accept;
   logic             launch_iter;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   logic [WIDTH-1:0] single_lo;
   logic [WIDTH-1:0] single_hi;
   logic             single_dz;
   logic             single_ill;
   logic [WIDTH-1:0] ror_val;
   logic [WIDTH-1:0] rol_val;

   logic             op_div;
   logic [WIDTH:0]   mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic             mul_q;
   logic [WIDTH:0]   mul_m;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   mul_hi_n;
   logic [WIDTH-1:0] mul_lo_n;

   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] div_dvs;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] div_rem_n;
   logic [WIDTH-1:0] div_quo_n;

   assign accept      = (state == IDLE) && bus.start;
   assign launch_iter = accept && ((bus.opcode == OP_MUL) ||
                                   ((bus.opcode == OP_DIV) && (bus.B != '0)));
   assign amt         = bus.B[SHW-1:0];
   assign abs_a       = bus.A[WIDTH-1] ? -bus.A : bus.A;
   assign abs_b       = bus.B[WIDTH-1] ? -bus.B : bus.B;
   assign bus.busy    = (state != IDLE);

   // State register; clear abandons any operation in flight.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: only MUL and a non-zero DIV leave IDLE; FIN lasts one cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (launch_iter) next_state = ITER;
         ITER:    if (count == '0) next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Rotates wrap their bit index modulo WIDTH, which is free since WIDTH is a power of 2.
   always_comb begin
      ror_val = '0;
      rol_val = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ror_val[i] = bus.A[SHW'(i) + amt];
         rol_val[i] = bus.A[SHW'(i) - amt];
      end
   end

   // Single-cycle results; a DIV that reaches here has a zero divisor.
   always_comb begin
      single_lo  = '0;
      single_hi  = '0;
      single_dz  = 1'b0;
      single_ill = 1'b0;
      case (bus.opcode)
         OP_LOAD, OP_ADD: single_lo = bus.A + bus.B;
         OP_SUB:          single_lo = bus.A - bus.B;
         OP_SHR:          single_lo = bus.A >> amt;
         OP_SHRA:         single_lo = $signed(bus.A) >>> amt;
         OP_SHL:          single_lo = bus.A << amt;
         OP_ROR:          single_lo = ror_val;
         OP_ROL:          single_lo = rol_val;
         OP_AND:          single_lo = bus.A & bus.B;
         OP_OR:           single_lo = bus.A | bus.B;
         OP_NEG:          single_lo = -bus.B;
         OP_NOT:          single_lo = ~bus.B;
         OP_MUL:          single_lo = '0;
         OP_DIV: begin
            single_hi = bus.A;
            single_dz = 1'b1;
         end
         default:         single_ill = 1'b1;
      endcase
   end

   // One Booth step and one restoring-division step per ITER cycle.
   always_comb begin
      mul_sum = mul_hi;
      case ({mul_lo[0], mul_q})
         2'b01:   mul_sum = mul_hi + mul_m;
         2'b10:   mul_sum = mul_hi - mul_m;
         default: mul_sum = mul_hi;
      endcase
      mul_hi_n  = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
      mul_lo_n  = {mul_sum[0], mul_lo[WIDTH-1:1]};
      div_shift = {div_rem, div_quo[WIDTH-1]};
      div_trial = div_shift - {1'b0, div_dvs};
      if (div_trial[WIDTH]) begin
         div_rem_n = div_shift[WIDTH-1:0];
         div_quo_n = {div_quo[WIDTH-2:0], 1'b0};
      end else begin
         div_rem_n = div_trial[WIDTH-1:0];
         div_quo_n = {div_quo[WIDTH-2:0], 1'b1};
      end
   end

   // Datapath: latch operands on accept, iterate, and publish results with a done pulse.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         bus.illegal_op  <= 1'b0;
         bus.Zlow        <= '0;
         bus.Zhigh       <= '0;
         count           <= '0;
         op_div          <= 1'b0;
         mul_hi          <= '0;
         mul_lo          <= '0;
         mul_q           <= 1'b0;
         mul_m           <= '0;
         div_rem         <= '0;
         div_quo         <= '0;
         div_dvs         <= '0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
      end else begin
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         bus.illegal_op  <= 1'b0;
         if (launch_iter) begin
            op_div  <= (bus.opcode == OP_DIV);
            count   <= SHW'(WIDTH - 1);
            mul_hi  <= '0;
            mul_lo  <= bus.B;
            mul_q   <= 1'b0;
            mul_m   <= {bus.A[WIDTH-1], bus.A};
            div_rem <= '0;
            div_quo <= abs_a;
            div_dvs <= abs_b;
            neg_q   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            neg_r   <= bus.A[WIDTH-1];
         end else if (accept) begin
            bus.Zlow        <= single_lo;
            bus.Zhigh       <= single_hi;
            bus.done        <= 1'b1;
            bus.div_by_zero <= single_dz;
            bus.illegal_op  <= single_ill;
         end else if (state == ITER) begin
            count   <= count - SHW'(1);
            mul_hi  <= mul_hi_n;
            mul_lo  <= mul_lo_n;
            mul_q   <= mul_lo[0];
            div_rem <= div_rem_n;
            div_quo <= div_quo_n;
            if (count == '0) begin
               bus.done <= 1'b1;
               if (op_div) begin
                  bus.Zlow  <= neg_q ? -div_quo_n : div_quo_n;
                  bus.Zhigh <= neg_r ? -div_rem_n : div_rem_n;
               end else begin
                  bus.Zlow  <= mul_lo_n;
                  bus.Zhigh <= mul_hi_n[WIDTH-1:0];
               end
            end
         end
      end
   end

endmodule
